// File: rtl/ibfu_pipe.sv
// -----------------------------------------------------------------------------
// ibfu_pipe -- pipelined radix-2 inverse butterfly.
//
// Undoes the forward DIT butterfly Ya = A + W*B, Yb = A - W*B:
//   Xa = (Ya + Yb) / 2            (floor, -0.5 LSB bias on odd sums)
//   Xb = conj(W) * (Ya - Yb) / 2  (round half up, saturated to DW bits)
// Three register stages share one advance enable, so the pipe either moves
// as a whole or holds as a whole. Bubbles travel with the data.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   in_valid/in_ready input handshake (in_ready = pipe may advance)
//   Yar,Yai,Ybr,Ybi   input samples, signed DW bits
//   Wr,Wi             forward twiddle, signed Q1.(TW-2)
//   out_valid/out_ready output handshake
//   Xar,Xai,Xbr,Xbi   recovered A and B, signed DW bits
// -----------------------------------------------------------------------------
module ibfu_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] Yar,
  input  logic [DW-1:0] Yai,
  input  logic [DW-1:0] Ybr,
  input  logic [DW-1:0] Ybi,
  input  logic [TW-1:0] Wr,
  input  logic [TW-1:0] Wi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] Xar,
  output logic [DW-1:0] Xai,
  output logic [DW-1:0] Xbr,
  output logic [DW-1:0] Xbi
);

  localparam int PW = DW + TW;      // product width
  localparam int AW = DW + TW + 1;  // product-sum width

  // Half-LSB of the output scale, and the saturation bounds at sum width.
  localparam logic signed [AW-1:0] RND  = AW'(2 ** (TW - 3));
  localparam logic signed [AW-1:0] SMAX = AW'(2 ** (DW - 1) - 1);
  localparam logic signed [AW-1:0] SMIN = AW'(-(2 ** (DW - 1)));

  // ---------------------------------------------------------------------------
  // Global advance: the pipe moves unless the last stage holds an output
  // that downstream is refusing.
  // ---------------------------------------------------------------------------
  logic adv;
  logic v1_q, v2_q, v3_q;

  assign adv      = !v3_q || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: half-sum and half-difference.
  // The DW+1 bit result shifted right by one (floor) is exactly bits [DW:1],
  // which always fits in DW bits.
  // ---------------------------------------------------------------------------
  logic signed [DW:0]   s_r, s_i, d_r, d_i;
  logic signed [DW-1:0] ar1_d, ai1_d, dr1_d, di1_d;
  logic signed [DW-1:0] ar1_q, ai1_q, dr1_q, di1_q;
  logic signed [TW-1:0] wr1_q, wi1_q;

  assign s_r = $signed({Yar[DW-1], Yar}) + $signed({Ybr[DW-1], Ybr});
  assign s_i = $signed({Yai[DW-1], Yai}) + $signed({Ybi[DW-1], Ybi});
  assign d_r = $signed({Yar[DW-1], Yar}) - $signed({Ybr[DW-1], Ybr});
  assign d_i = $signed({Yai[DW-1], Yai}) - $signed({Ybi[DW-1], Ybi});

  always_comb begin
    ar1_d = s_r[DW:1];
    ai1_d = s_i[DW:1];
    dr1_d = d_r[DW:1];
    di1_d = d_i[DW:1];
  end

  // ---------------------------------------------------------------------------
  // Stage 2: the four partial products of conj(W) * D. A is delayed alongside.
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] prr_d, pii_d, pir_d, pri_d;
  logic signed [PW-1:0] prr_q, pii_q, pir_q, pri_q;
  logic signed [DW-1:0] ar2_q, ai2_q;

  always_comb begin
    prr_d = PW'(dr1_q) * PW'(wr1_q);  // Dr*Wr
    pii_d = PW'(di1_q) * PW'(wi1_q);  // Di*Wi
    pir_d = PW'(di1_q) * PW'(wr1_q);  // Di*Wr
    pri_d = PW'(dr1_q) * PW'(wi1_q);  // Dr*Wi
  end

  // ---------------------------------------------------------------------------
  // Stage 3: combine, round half up, rescale from Q1.(TW-2), saturate.
  // ---------------------------------------------------------------------------
  logic signed [AW-1:0] pr_sum, pi_sum;
  logic signed [AW-1:0] pr_rnd, pi_rnd;
  logic signed [AW-1:0] pr_shf, pi_shf;
  logic signed [DW-1:0] xbr_d, xbi_d;
  logic signed [DW-1:0] xar_q, xai_q, xbr_q, xbi_q;

  function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] x);
    logic signed [DW-1:0] r;
    if (x > SMAX) begin
      r = SMAX[DW-1:0];
    end else if (x < SMIN) begin
      r = SMIN[DW-1:0];
    end else begin
      r = x[DW-1:0];
    end
    return r;
  endfunction

  always_comb begin
    pr_sum = AW'(prr_q) + AW'(pii_q);
    pi_sum = AW'(pir_q) - AW'(pri_q);
    pr_rnd = pr_sum + RND;
    pi_rnd = pi_sum + RND;
    pr_shf = pr_rnd >>> (TW - 2);
    pi_shf = pi_rnd >>> (TW - 2);
    xbr_d  = sat(pr_shf);
    xbi_d  = sat(pi_shf);
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. Reset clears valids and data so the outputs read 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      ar1_q <= '0;
      ai1_q <= '0;
      dr1_q <= '0;
      di1_q <= '0;
      wr1_q <= '0;
      wi1_q <= '0;
      prr_q <= '0;
      pii_q <= '0;
      pir_q <= '0;
      pri_q <= '0;
      ar2_q <= '0;
      ai2_q <= '0;
      xar_q <= '0;
      xai_q <= '0;
      xbr_q <= '0;
      xbi_q <= '0;
    end else if (adv) begin
      v1_q  <= in_valid;
      ar1_q <= ar1_d;
      ai1_q <= ai1_d;
      dr1_q <= dr1_d;
      di1_q <= di1_d;
      wr1_q <= $signed(Wr);
      wi1_q <= $signed(Wi);

      v2_q  <= v1_q;
      prr_q <= prr_d;
      pii_q <= pii_d;
      pir_q <= pir_d;
      pri_q <= pri_d;
      ar2_q <= ar1_q;
      ai2_q <= ai1_q;

      v3_q  <= v2_q;
      xar_q <= ar2_q;
      xai_q <= ai2_q;
      xbr_q <= xbr_d;
      xbi_q <= xbi_d;
    end
  end

  assign out_valid = v3_q;
  assign Xar       = xar_q;
  assign Xai       = xai_q;
  assign Xbr       = xbr_q;
  assign Xbi       = xbi_q;

endmodule

// File: tb/tb_ibfu_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for ibfu_pipe: directed cases plus randomized streaming under
// random and patterned backpressure. Expected results are queued at input
// acceptance and consumed by an independent output monitor.
// -----------------------------------------------------------------------------
module tb_ibfu_pipe;

  localparam int DW = 16;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] Yar, Yai, Ybr, Ybi;
  logic [TW-1:0] Wr, Wi;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] Xar, Xai, Xbr, Xbi;

  typedef struct {
    int ar;
    int ai;
    int br;
    int bi;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   or_mode  = 0;  // 0: ready=1, 1: random, 2: 1,0,0 pattern, 3: ready=0

  ibfu_pipe #(.DW(DW), .TW(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Yar      (Yar),
    .Yai      (Yai),
    .Ybr      (Ybr),
    .Ybi      (Ybi),
    .Wr       (Wr),
    .Wi       (Wi),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Xar      (Xar),
    .Xai      (Xai),
    .Xbr      (Xbr),
    .Xbi      (Xbi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int s16(input logic [DW-1:0] v);
    logic signed [DW-1:0] t;
    t = v;
    return t;
  endfunction

  function automatic int rnd16();
    logic signed [DW-1:0] t;
    t = DW'($urandom);
    return t;
  endfunction

  function automatic longint clamp(input longint v);
    longint hi, lo;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: A = floor((Ya+Yb)/2), D = floor((Ya-Yb)/2),
  // B = sat(round_half_up(conj(W)*D / 2^(TW-2))).
  function automatic exp_t model(input int yar, input int yai, input int ybr,
                                 input int ybi, input int wr, input int wi);
    exp_t   e;
    int     dr, di;
    longint pr, pi, half;
    half = longint'(1) <<< (TW - 3);
    e.ar = (yar + ybr) >>> 1;
    e.ai = (yai + ybi) >>> 1;
    dr   = (yar - ybr) >>> 1;
    di   = (yai - ybi) >>> 1;
    pr   = longint'(dr) * wr + longint'(di) * wi;
    pi   = longint'(di) * wr - longint'(dr) * wi;
    e.br = int'(clamp((pr + half) >>> (TW - 2)));
    e.bi = int'(clamp((pi + half) >>> (TW - 2)));
    return e;
  endfunction

  // Presents one beat (called just after a rising edge), queues its expected
  // result when accepted, and returns just after the transfer edge.
  task automatic send(input int yar, input int yai, input int ybr, input int ybi,
                      input int wr, input int wi, input exp_t e);
    logic acc;
    acc = 1'b0;
    Yar = DW'(yar);
    Yai = DW'(yai);
    Ybr = DW'(ybr);
    Ybi = DW'(ybi);
    Wr  = TW'(wr);
    Wi  = TW'(wi);
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) sb.push_back(e);
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic send_m(input int yar, input int yai, input int ybr, input int ybi,
                        input int wr, input int wi);
    send(yar, yai, ybr, ybi, wr, wi, model(yar, yai, ybr, ybi, wr, wi));
  endtask

  task automatic drain();
    for (int n = 0; n < 500 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // out_ready driver
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          out_ready = (cnt % 3 == 0);
          cnt++;
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: handshake rule, hold stability, in-order scoreboard.
  initial begin
    logic          held;
    logic [DW-1:0] h_ar, h_ai, h_br, h_bi;
    exp_t          e;
    held = 1'b0;
    h_ar = '0;
    h_ai = '0;
    h_br = '0;
    h_bi = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        check("in_ready_rule", int'(in_ready), int'(!(out_valid && !out_ready)));
        if (held) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_Xar", s16(Xar), s16(h_ar));
          check("hold_Xai", s16(Xai), s16(h_ai));
          check("hold_Xbr", s16(Xbr), s16(h_br));
          check("hold_Xbi", s16(Xbi), s16(h_bi));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = sb.pop_front();
            check("Xar", s16(Xar), e.ar);
            check("Xai", s16(Xai), e.ai);
            check("Xbr", s16(Xbr), e.br);
            check("Xbi", s16(Xbi), e.bi);
          end
        end
        held = out_valid && !out_ready;
        h_ar = Xar;
        h_ai = Xai;
        h_br = Xbr;
        h_bi = Xbi;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // Main stimulus
  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Yar = '0; Yai = '0; Ybr = '0; Ybi = '0; Wr = '0; Wi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_Xar", s16(Xar), 0);
    check("rst_Xbi", s16(Xbi), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Identity twiddle, with latency and single-cycle valid.
    send(100, 50, 20, -10, 16384, 0, '{60, 20, 40, 30});
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 3);
    @(posedge clk);
    #1;
    check("valid_one_cycle", int'(out_valid), 0);
    drain();

    // W = j
    send(100, 50, 20, -10, 0, 16384, '{60, 20, 30, -40});
    // Floor on odd sums and differences
    send(3, -3, 0, 0, 16384, 0, '{1, -2, 1, -2});
    // Rounding: D=(1,-2), W=0.5 -> 0.5 rounds up, -1.0 stays
    send(2, -4, 0, 0, 8192, 0, '{1, -2, 1, -1});
    // Saturation
    send(32767, 32767, -32768, -32768, -16384, -16384, '{-1, -1, -32768, 0});
    drain();

    // Backpressure pattern 1,0,0,... with 8 back-to-back beats.
    or_mode = 2;
    for (int i = 0; i < 8; i++) send_m(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    drain();

    // Randomized stream with gaps and random backpressure.
    or_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_m(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    end
    drain();

    // Reset with three beats in flight.
    or_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_m(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_Xar", s16(Xar), 0);
    check("midrst_Xai", s16(Xai), 0);
    check("midrst_Xbr", s16(Xbr), 0);
    check("midrst_Xbi", s16(Xbi), 0);
    or_mode = 0;
    @(posedge clk);
    #1;
    send(100, 50, 20, -10, 16384, 0, '{60, 20, 40, 30});
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("post_rst_latency", lat, 3);
    drain();

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
